// File: rtl/fetch_unit_if.sv
// Signal bundle between the instruction decoder/RAM side and the fetch unit.
// The fetch unit takes the slave modport; the decoder side takes the master modport.
interface fetch_unit_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 32
);
  logic                 cnt_en;
  logic                 pc_sload;
  logic [WIDTH-1:0]     new_pc;
  logic                 stall;
  logic [WIDTH-1:0]     instr_q1;
  logic [WIDTH-1:0]     instr_q2;
  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     instr;
  logic [WIDTH-1:0]     N;
  logic                 valid;
  logic                 halted;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    output cnt_en, pc_sload, new_pc, stall, instr_q1, instr_q2,
    input  pc, instr, N, valid, halted, retired
  );

  modport slave (
    input  cnt_en, pc_sload, new_pc, stall, instr_q1, instr_q2,
    output pc, instr, N, valid, halted, retired
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: owns the program counter, presents instruction/immediate words to the
// decoder, and handles boot, stall/replay, STP halt and a saturating retired counter.
module fetch_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = {WIDTH{1'b0}},
  parameter int               CNT_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0]     PC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]     hold_instr_q, hold_instr_d;
  logic [WIDTH-1:0]     hold_n_q, hold_n_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [WIDTH-1:0]     instr_s;
  logic [WIDTH-1:0]     n_s;

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      hold_instr_q <= {WIDTH{1'b0}};
      hold_n_q     <= {WIDTH{1'b0}};
      retired_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_n_q     <= hold_n_d;
      retired_q    <= retired_d;
    end
  end

  // Next-state and word selection; stalled RUN and HALT replay the held words.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_n_d     = hold_n_q;
    retired_d    = retired_q;
    instr_s      = {WIDTH{1'b0}};
    n_s          = {WIDTH{1'b0}};
    case (state_q)
      BOOT: begin
        if (!bus.stall) begin
          state_d = RUN;
        end else begin
          state_d = BOOT;
        end
      end
      RUN: begin
        if (bus.stall) begin
          instr_s = hold_instr_q;
          n_s     = hold_n_q;
        end else begin
          instr_s      = bus.instr_q1;
          n_s          = bus.instr_q2;
          hold_instr_d = bus.instr_q1;
          hold_n_d     = bus.instr_q2;
          if (bus.pc_sload) begin
            pc_d = bus.new_pc;
          end else if (bus.cnt_en) begin
            pc_d = pc_q + PC_ONE;
          end else begin
            pc_d = pc_q;
          end
          if (retired_q != CNT_MAX) begin
            retired_d = retired_q + CNT_ONE;
          end else begin
            retired_d = retired_q;
          end
          // STP opcode: top five bits all ones
          if (bus.instr_q1[WIDTH-1 -: 5] == 5'b11111) begin
            state_d = HALT;
          end else begin
            state_d = RUN;
          end
        end
      end
      HALT: begin
        instr_s = hold_instr_q;
        n_s     = hold_n_q;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.instr   = instr_s;
  assign bus.N       = n_s;
  assign bus.valid   = (state_q == RUN);
  assign bus.halted  = (state_q == HALT);
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus randomized
// traffic, all outputs compared every cycle against a behavioural model.
module tb_fetch_unit;
  localparam int CW      = 6;
  localparam int CNT_MAX = 63;

  logic clk;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  fetch_unit_if #(.WIDTH(16), .CNT_WIDTH(CW)) bus ();

  fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 = boot, 1 = run, 2 = halted
  int  m_mode;
  int  m_pc;
  int  m_hi;
  int  m_hn;
  int  m_ret;
  bit  m_known = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic ce, input logic sl, input logic [15:0] npc,
                       input logic st, input logic [15:0] q1, input logic [15:0] q2);
    int ei, en;
    reset        = r;
    bus.cnt_en   = ce;
    bus.pc_sload = sl;
    bus.new_pc   = npc;
    bus.stall    = st;
    bus.instr_q1 = q1;
    bus.instr_q2 = q2;
    #1;
    if (m_known) begin
      if (m_mode == 0) begin ei = 0; en = 0; end
      else if (m_mode == 2 || st) begin ei = m_hi; en = m_hn; end
      else begin ei = q1; en = q2; end
      check("pc", bus.pc, m_pc);
      check("instr", bus.instr, ei);
      check("N", bus.N, en);
      check("valid", bus.valid, (m_mode == 1) ? 1 : 0);
      check("halted", bus.halted, (m_mode == 2) ? 1 : 0);
      check("retired", bus.retired, m_ret);
    end
  endtask

  task automatic tick();
    int nm, np, nhi, nhn, nr;
    nm = m_mode; np = m_pc; nhi = m_hi; nhn = m_hn; nr = m_ret;
    if (reset) begin
      nm = 0; np = 0; nhi = 0; nhn = 0; nr = 0;
    end else if (m_mode == 0) begin
      if (!bus.stall) nm = 1;
    end else if (m_mode == 1 && !bus.stall) begin
      nhi = bus.instr_q1;
      nhn = bus.instr_q2;
      if (bus.pc_sload) np = bus.new_pc;
      else if (bus.cnt_en) np = (m_pc + 1) % 65536;
      if (m_ret < CNT_MAX) nr = m_ret + 1;
      if ((int'(bus.instr_q1) >> 11) == 31) nm = 2;
    end
    @(posedge clk);
    if (reset) m_known = 1'b1;
    m_mode = nm; m_pc = np; m_hi = nhi; m_hn = nhn; m_ret = nr;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] q1;
    logic        st;
    @(negedge clk);
    // Reset release and boot
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4801, 16'h0000); tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4801, 16'h0000); tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4801, 16'h0002);
    check("boot_instr", bus.instr, 16'h0000);
    check("boot_valid", bus.valid, 1'b0);
    check("boot_pc", bus.pc, 16'h0000);
    tick();
    // Sequential run
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h4801, 16'h0002);
    check("run_valid", bus.valid, 1'b1);
    check("run_instr", bus.instr, 16'h4801);
    tick();
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0101, 16'h0003);
    check("seq_pc1", bus.pc, 16'h0001);
    tick();
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0202, 16'h0004);
    check("seq_pc2", bus.pc, 16'h0002);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0303, 16'h0005);
    check("seq_pc3", bus.pc, 16'h0003);
    check("seq_retired", bus.retired, 3);
    tick();
    // Wrap and load priority
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0404, 16'h0006); tick();
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0505, 16'h0007);
    check("wrap_pre", bus.pc, 16'hFFFF);
    tick();
    drive(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0606, 16'h0008);
    check("wrap_pc", bus.pc, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, 16'h5678);
    check("load_pc", bus.pc, 16'h0040);
    tick();
    // Stall replay
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 16'h9999);
    check("stall_instr1", bus.instr, 16'h1234);
    check("stall_n1", bus.N, 16'h5678);
    tick();
    drive(1'b0, 1'b1, 1'b1, 16'h0777, 1'b1, 16'hBEEF, 16'h9999);
    check("stall_instr2", bus.instr, 16'h1234);
    check("stall_pc", bus.pc, 16'h0040);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 16'h9999);
    check("release_instr", bus.instr, 16'hBEEF);
    check("stall_retired", bus.retired, 8);
    check("release_pc", bus.pc, 16'h0040);
    tick();
    // Halt on STP
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hF800, 16'h00AA); tick();
    drive(1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 16'h0000, 16'h0000);
    check("halt_halted", bus.halted, 1'b1);
    check("halt_valid", bus.valid, 1'b0);
    check("halt_instr", bus.instr, 16'hF800);
    check("halt_pc", bus.pc, 16'h0041);
    check("halt_retired", bus.retired, 10);
    tick();
    drive(1'b0, 1'b1, 1'b1, 16'h2222, 1'b0, 16'h0000, 16'h0000);
    check("halt_pc2", bus.pc, 16'h0041);
    check("halt_ret2", bus.retired, 10);
    tick();
    // Reset from halt
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4801, 16'h0000); tick();
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h4801, 16'h0000);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_pc", bus.pc, 16'h0000);
    check("rst_retired", bus.retired, 0);
    check("rst_instr", bus.instr, 16'h0000);
    tick();
    // Counter saturation: 69 RUN cycles after the boot cycle above
    repeat (69) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0123, 16'h0000); tick();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0123, 16'h0000);
    check("sat_retired", bus.retired, CNT_MAX);
    check("sat_pc", bus.pc, 16'h0045);
    tick();
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      q1 = 16'($urandom);
      if ($urandom_range(0, 149) == 0) q1[15:11] = 5'b11111;
      else if (q1[15:11] == 5'b11111) q1[15] = 1'b0;
      st = ($urandom_range(0, 3) == 0);
      drive(($urandom_range(0, 199) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
            16'($urandom), st, q1, 16'($urandom));
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream neighbour of the instruction decoder. Owns the program counter and the instruction/immediate words presented to the decoder.
- Consumes the decoder's PC-control outputs (cnt_en, pc_sload, new_pc) and the 1-cycle-latency dual-port instruction RAM read data. Produces pc, instr and N for the decoder.
- Handles boot after reset, stall/replay and STP halt, and keeps a retired-instruction counter for debug.

Parameters:
- WIDTH, 16, width of pc, instruction words and N.
- RESET_PC, 16'h0000, value loaded into pc on reset.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cnt_en  input  1  from decoder: increment pc.
- pc_sload  input  1  from decoder: load new_pc into pc.
- new_pc  input  WIDTH  from decoder: pc load value.
- stall  input  1  freeze pc, state, outputs and counter this cycle.
- instr_q1  input  WIDTH  instruction RAM port-1 read data (address issued previous cycle).
- instr_q2  input  WIDTH  instruction RAM port-2 read data (immediate N).
- pc  output  WIDTH  current program counter (registered).
- instr  output  WIDTH  instruction word to decoder.
- N  output  WIDTH  immediate/second word to decoder.
- valid  output  1  instr/N hold real RAM data (RUN state).
- halted  output  1  STP executed; core frozen.
- retired  output  CNT_WIDTH  count of instructions accepted in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on reset. Reset takes priority over every other input.
- Reset values: pc = RESET_PC, state = BOOT, hold_instr = 0, hold_N = 0, retired = 0, valid = 0, halted = 0.
- States:
  - BOOT: instr and N forced to 0 (NOP). The decoder therefore issues RAM addresses pc and pc+1. Next non-stalled cycle -> RUN. pc is not updated in BOOT.
  - RUN: instr = instr_q1 and N = instr_q2 (combinational pass-through). hold_instr/hold_N capture them every non-stalled cycle.
    - pc update: if pc_sload then pc <= new_pc; else if cnt_en then pc <= pc + 1; else hold. pc_sload has priority when both are high.
    - Increment wraps modulo 2^WIDTH (FFFF -> 0000); no flag.
    - retired increments by 1 each non-stalled RUN cycle and saturates at all-ones.
    - If instr[15:11] == 5'b11111 (STP), the same edge goes -> HALT. STP counts as retired. pc update still applies that cycle per cnt_en/pc_sload.
  - HALT: instr = hold_instr (the STP), N = hold_N, valid = 0, halted = 1. pc, holds and retired are frozen; cnt_en, pc_sload and stall are ignored. Exit only via reset.
- Stall, any state except HALT:
  - state, pc, holds and retired unchanged.
  - instr/N driven from hold_instr/hold_N, so the decoder sees a stable word while the RAM may return other data.
  - valid stays at its RUN/BOOT value.
  - In BOOT, a stall keeps the block in BOOT with NOP output.
- Stall release: outputs revert to the RAM pass-through. The RAM address is derived from the unchanged pc, so the same word is re-presented (replay).
- valid = 1 only in RUN. halted = 1 only in HALT.
- Reset mid-RUN or mid-HALT: next cycle BOOT with pc = RESET_PC, counter cleared, NOP presented.
- pc_sload/cnt_en arriving in BOOT or HALT are ignored (no pc change).
- Latency: pc change is visible the cycle after the load/increment request; RAM data for that pc is visible on instr the following cycle.

Test Plan:
- Reset release: reset high 2 cycles, then low with instr_q1=16'h4801 -> BOOT cycle shows instr=0000, valid=0, pc=0000; next cycle valid=1, instr=4801.
- Sequential run: RUN with cnt_en=1 for 3 cycles -> pc 0000->0001->0002->0003; retired=3.
- Load priority and wrap: pc=FFFF, cnt_en=1 -> pc=0000. Then cnt_en=1, pc_sload=1, new_pc=0040 -> pc=0040.
- Stall replay: RUN with instr_q1=1234; assert stall 2 cycles while instr_q1 changes to BEEF -> instr stays 1234, pc and retired frozen. After release, instr follows instr_q1.
- Halt: instr_q1=F800 (STP) in RUN -> next cycle halted=1, valid=0, instr=F800. Further cnt_en/pc_sload/stall leave pc and retired unchanged.
- Reset from HALT: assert reset while halted -> next cycle halted=0, pc=RESET_PC, retired=0, instr=0000 (BOOT).
